// File: rtl/cache_controller.sv
// cache_controller: two-way set-associative, write-through, no-write-allocate
// cache sitting between the MEM stage and the SRAM controller. Read hits are
// answered combinationally; misses and every store go out over the SRAM
// request/ready handshake while `ready` holds the pipeline.
module cache_controller #(
    parameter int unsigned SETS  = 64,
    parameter int unsigned TAG_W = 10,
    parameter int unsigned BASE  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] readData,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_write_en,
    output logic        sram_read_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int unsigned IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

    state_t state_q, state_d;

    logic             valid_q [2][SETS];
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [63:0]      data_q  [2][SETS];
    logic             lru_q   [SETS];

    logic [31:0]      a;
    logic             word_sel;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_addr_bits;

    logic             hit0, hit1, hit, hit_way, victim;
    logic [63:0]      hit_block;
    logic [31:0]      hit_word, fill_word;

    logic             fill_en, wr_upd, lru_upd, lru_val;

    assign a        = address - 32'(BASE);
    assign word_sel = a[2];
    assign idx      = a[IDX_W+2:3];
    assign tag      = a[IDX_W+3 +: TAG_W];
    assign unused_addr_bits = ^{a[31:IDX_W+3+TAG_W], a[1:0]};

    assign hit0      = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1      = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit       = hit0 | hit1;
    assign hit_way   = hit1;
    assign hit_block = hit_way ? data_q[1][idx] : data_q[0][idx];
    assign hit_word  = word_sel ? hit_block[63:32] : hit_block[31:0];
    assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];

    // Invalid ways are filled before any valid line is evicted.
    assign victim = !valid_q[0][idx] ? 1'b0 :
                    !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    assign sram_address  = address;
    assign sram_wdata    = writeData;
    assign sram_read_en  = (state_q == RD_MISS);
    assign sram_write_en = (state_q == WR);

    // Next-state, pipeline handshake and cache-update strobes.
    always_comb begin
        state_d  = state_q;
        ready    = 1'b1;
        readData = '0;
        fill_en  = 1'b0;
        wr_upd   = 1'b0;
        lru_upd  = 1'b0;
        lru_val  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MEM_W_EN) begin
                    ready   = 1'b0;
                    state_d = WR;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        readData = hit_word;
                        lru_upd  = 1'b1;
                        lru_val  = ~hit_way;
                    end else begin
                        ready   = 1'b0;
                        state_d = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                ready = sram_ready;
                if (sram_ready) begin
                    readData = fill_word;
                    fill_en  = 1'b1;
                    lru_upd  = 1'b1;
                    lru_val  = ~victim;
                    state_d  = IDLE;
                end
            end
            WR: begin
                ready = sram_ready;
                if (sram_ready) begin
                    state_d = IDLE;
                    if (hit) begin
                        wr_upd  = 1'b1;
                        lru_upd = 1'b1;
                        lru_val = ~hit_way;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state plus valid/LRU bookkeeping; reset invalidates the whole cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[0][s] <= 1'b0;
                valid_q[1][s] <= 1'b0;
                lru_q[s]      <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            if (fill_en) valid_q[victim][idx] <= 1'b1;
            if (lru_upd) lru_q[idx] <= lru_val;
        end
    end

    // Tag/data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[victim][idx]  <= tag;
            data_q[victim][idx] <= sram_rdata;
        end
        if (wr_upd) begin
            if (word_sel) data_q[hit_way][idx][63:32] <= writeData;
            else          data_q[hit_way][idx][31:0]  <= writeData;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed checks of the cache controller against a
// small SRAM-controller model whose ready rises four cycles into a request.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, writeData, readData, sram_address, sram_wdata;
    logic        MEM_R_EN, MEM_W_EN, ready;
    logic        sram_write_en, sram_read_en, sram_ready;
    logic [63:0] sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int LAT = 4;
    int cnt;

    always #5 clk = ~clk;

    cache_controller #(.SETS(64), .TAG_W(10), .BASE(1024)) dut (
        .clk(clk), .rst(rst), .address(address), .writeData(writeData),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .readData(readData),
        .ready(ready), .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    // SRAM controller model: idle reports ready; busy for LAT cycles per request.
    always @(posedge clk) begin
        if (rst || !(sram_read_en || sram_write_en)) cnt <= 0;
        else cnt <= cnt + 1;
    end
    assign sram_ready = !(sram_read_en || sram_write_en) ? 1'b1 : (cnt == LAT);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    // Issue one request and hold it until ready; cycles = 1 means same-cycle.
    task automatic run_req(input logic w, input logic r, input logic [31:0] addr,
                           input logic [31:0] wd, output int cycles,
                           output logic [31:0] rd, output logic saw_rd,
                           output logic saw_wr);
        address = addr; writeData = wd; MEM_W_EN = w; MEM_R_EN = r;
        saw_rd = 1'b0; saw_wr = 1'b0; cycles = 99; rd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            saw_rd = saw_rd | sram_read_en;
            saw_wr = saw_wr | sram_write_en;
            if (ready) begin
                cycles = c;
                rd = readData;
                break;
            end
        end
        tick;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        address = 32'd1024;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_checks++; if (readData !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", readData); end
        n_checks++; if (sram_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", sram_read_en); end
        n_checks++; if (sram_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", sram_write_en); end
        n_checks++; if (sram_address !== 32'd1024) begin n_fail++; $display("FAIL sram_address: got %h expected %h", sram_address, 32'd1024); end
        MEM_R_EN = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_miss_ready: got %b expected 0", ready); end
        MEM_R_EN = 1'b0;
        tick;
    endtask

    task automatic test_write_miss;
        int cyc; logic [31:0] rd; logic srd, swr;
        run_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL wmiss_cycles: got %0d expected 6", cyc); end
        n_checks++; if (swr !== 1'b1) begin n_fail++; $display("FAIL wmiss_wr_en: got %b expected 1", swr); end
        n_checks++; if (srd !== 1'b0) begin n_fail++; $display("FAIL wmiss_rd_en: got %b expected 0", srd); end
        n_checks++; if (sram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wmiss_wdata: got %h expected deadbeef", sram_wdata); end
        sram_rdata = 64'h11111111_DEADBEEF;
        run_req(1'b0, 1'b1, 32'd1024, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL noalloc_cycles: got %0d expected 6", cyc); end
        n_checks++; if (srd !== 1'b1) begin n_fail++; $display("FAIL noalloc_rd_en: got %b expected 1", srd); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fill_rdata: got %h expected deadbeef", rd); end
    endtask

    task automatic test_fill_hit;
        int cyc; logic [31:0] rd; logic srd, swr;
        run_req(1'b0, 1'b1, 32'd1028, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL hit_cycles: got %0d expected 1", cyc); end
        n_checks++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL hit_rdata: got %h expected 11111111", rd); end
        n_checks++; if ((srd | swr) !== 1'b0) begin n_fail++; $display("FAIL hit_sram_en: got %b expected 0", srd | swr); end
    endtask

    task automatic test_write_hit;
        int cyc; logic [31:0] rd; logic srd, swr;
        run_req(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL whit_cycles: got %0d expected 6", cyc); end
        n_checks++; if (swr !== 1'b1) begin n_fail++; $display("FAIL whit_wr_en: got %b expected 1", swr); end
        run_req(1'b0, 1'b1, 32'd1028, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL whit_rd_cycles: got %0d expected 1", cyc); end
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL whit_rdata: got %h expected cafef00d", rd); end
        n_checks++; if (srd !== 1'b0) begin n_fail++; $display("FAIL whit_rd_en: got %b expected 0", srd); end
        run_req(1'b0, 1'b1, 32'd1024, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL whit_other_word: got %h expected deadbeef", rd); end
    endtask

    task automatic test_lru_evict;
        int cyc; logic [31:0] rd; logic srd, swr;
        do_reset;
        sram_rdata = 64'hAAAA0001_AAAA0000;
        run_req(1'b0, 1'b1, 32'd1024, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (rd !== 32'hAAAA0000) begin n_fail++; $display("FAIL lru_fill1024: got %h expected aaaa0000", rd); end
        sram_rdata = 64'hBBBB0001_BBBB0000;
        run_req(1'b0, 1'b1, 32'd1536, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL lru_miss1536: got %0d cycles expected 6", cyc); end
        run_req(1'b0, 1'b1, 32'd1024, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL lru_hit1024: got %0d cycles expected 1", cyc); end
        sram_rdata = 64'hCCCC0001_CCCC0000;
        run_req(1'b0, 1'b1, 32'd2048, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (rd !== 32'hCCCC0000) begin n_fail++; $display("FAIL lru_fill2048: got %h expected cccc0000", rd); end
        run_req(1'b0, 1'b1, 32'd1024, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL lru_keep1024: got %0d cycles expected 1", cyc); end
        n_checks++; if (rd !== 32'hAAAA0000) begin n_fail++; $display("FAIL lru_keep1024_data: got %h expected aaaa0000", rd); end
        sram_rdata = 64'hDDDD0001_DDDD0000;
        run_req(1'b0, 1'b1, 32'd1536, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL lru_evicted1536: got %0d cycles expected 6", cyc); end
    endtask

    task automatic test_reset_mid_miss;
        int cyc; logic [31:0] rd; logic srd, swr;
        do_reset;
        sram_rdata = 64'hEEEE0001_EEEE0000;
        run_req(1'b0, 1'b1, 32'd1024, 32'h0, cyc, rd, srd, swr);
        address = 32'd2048; MEM_R_EN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (sram_read_en !== 1'b1) begin n_fail++; $display("FAIL midmiss_rd_en: got %b expected 1", sram_read_en); end
        rst = 1'b1;
        tick;
        rst = 1'b0; MEM_R_EN = 1'b0;
        @(negedge clk);
        n_checks++; if ({sram_read_en, sram_write_en} !== 2'b00) begin n_fail++; $display("FAIL midrst_en: got %b expected 00", {sram_read_en, sram_write_en}); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", ready); end
        tick;
        run_req(1'b0, 1'b1, 32'd1028, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL midrst_invalid: got %0d cycles expected 6", cyc); end
        n_checks++; if (rd !== 32'hEEEE0001) begin n_fail++; $display("FAIL midrst_rdata: got %h expected eeee0001", rd); end
    endtask

    task automatic test_both_enables;
        int cyc; logic [31:0] rd; logic srd, swr;
        run_req(1'b1, 1'b1, 32'd1024, 32'h55AA55AA, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL both_cycles: got %0d expected 6", cyc); end
        n_checks++; if (srd !== 1'b0) begin n_fail++; $display("FAIL both_rd_en: got %b expected 0", srd); end
        n_checks++; if (swr !== 1'b1) begin n_fail++; $display("FAIL both_wr_en: got %b expected 1", swr); end
        run_req(1'b0, 1'b1, 32'd1024, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL both_rdata: got %h expected 55aa55aa", rd); end
    endtask

    task automatic test_back_to_back;
        int cyc; logic [31:0] rd; logic srd, swr;
        sram_rdata = 64'hF0F00001_F0F00000;
        run_req(1'b0, 1'b1, 32'd2048, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (rd !== 32'hF0F00000) begin n_fail++; $display("FAIL b2b_first: got %h expected f0f00000", rd); end
        sram_rdata = 64'h12340001_12340000;
        run_req(1'b0, 1'b1, 32'd1536, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL b2b_second_cycles: got %0d expected 6", cyc); end
        n_checks++; if (rd !== 32'h12340000) begin n_fail++; $display("FAIL b2b_second: got %h expected 12340000", rd); end
        run_req(1'b0, 1'b1, 32'd2052, 32'h0, cyc, rd, srd, swr);
        n_checks++; if (rd !== 32'hF0F00001 || cyc !== 1) begin n_fail++; $display("FAIL b2b_hit2052: got %h/%0d expected f0f00001/1", rd, cyc); end
    endtask

    initial begin
        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        address = '0; writeData = '0; sram_rdata = '0;
        test_reset;
        test_write_miss;
        test_fill_hit;
        test_write_hit;
        test_lru_evict;
        test_reset_mid_miss;
        test_both_enables;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
